// File: rtl/divider_signed_frontend_pkg.sv
// Shared definitions for the signed divider front end: FSM encoding and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dividerPkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Most negative two's-complement value (100..0) for a w-bit word, w <= 64.
  function automatic logic [63:0] min_neg_of(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // All-ones word (11..1) for a w-bit word, w <= 64.
  function automatic logic [63:0] all_ones_of(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/divider_sign_fix.sv
// Sign correction of unsigned core results for signed division.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module divider_sign_fix #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] mag_quotient_i,
  input  logic [WIDTH-1:0] mag_remainder_i,
  input  logic             dividend_neg_i,
  input  logic             divisor_neg_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement negate, wrapping mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  // Quotient flips when signs differ; remainder follows the dividend sign.
  always_comb begin
    quotient_o  = mag_quotient_i;
    remainder_o = mag_remainder_i;
    if (signed_i) begin
      if (dividend_neg_i ^ divisor_neg_i) quotient_o  = neg2c(mag_quotient_i);
      if (dividend_neg_i)                 remainder_o = neg2c(mag_remainder_i);
    end
  end

endmodule

// File: rtl/divider_signed_frontend.sv
// Signed/unsigned request front end for the iterative unsigned divider core.
// Latency: special cases respond 1 cycle after accept; normal case responds 1 cycle after core done.
// Backpressure: holds the response until i_rsp_ready; accepts requests only in IDLE.
module divider_signed_frontend
  import dividerPkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cg,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_signed,
  input  logic [WIDTH-1:0] i_req_dividend,
  input  logic [WIDTH-1:0] i_req_divisor,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_quotient,
  output logic [WIDTH-1:0] o_rsp_remainder,
  output logic             o_rsp_divzero,
  output logic             o_rsp_overflow,
  output logic             o_div_start,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  input  logic             i_div_done,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic [WIDTH-1:0] i_div_remainder
);

  localparam logic [WIDTH-1:0] MIN_NEG  = WIDTH'(min_neg_of(WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones_of(WIDTH));
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divzero_q, divzero_d;
  logic             overflow_q, overflow_d;

  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;
  logic [WIDTH-1:0] fix_quot, fix_rem;

  divider_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mag_quotient_i  (i_div_quotient),
    .mag_remainder_i (i_div_remainder),
    .dividend_neg_i  (a_neg_q),
    .divisor_neg_i   (b_neg_q),
    .signed_i        (signed_q),
    .quotient_o      (fix_quot),
    .remainder_o     (fix_rem)
  );

  // Operand signs and magnitudes; MIN_NEG maps onto itself, which is correct unsigned.
  always_comb begin
    in_a_neg = i_req_signed & i_req_dividend[WIDTH-1];
    in_b_neg = i_req_signed & i_req_divisor[WIDTH-1];
    in_a_mag = in_a_neg ? (~i_req_dividend + ONE) : i_req_dividend;
    in_b_mag = in_b_neg ? (~i_req_divisor  + ONE) : i_req_divisor;
  end

  // Next-state logic: capture on accept, resolve special cases locally, collect core result.
  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    signed_d   = signed_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divzero_d  = divzero_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          a_mag_d  = in_a_mag;
          b_mag_d  = in_b_mag;
          a_neg_d  = in_a_neg;
          b_neg_d  = in_b_neg;
          signed_d = i_req_signed;
          if (i_req_divisor == '0) begin
            quot_d     = ALL_ONES;
            rem_d      = i_req_dividend;
            divzero_d  = 1'b1;
            overflow_d = 1'b0;
            state_d    = ST_RESP;
          end else if (i_req_signed && (i_req_dividend == MIN_NEG) &&
                       (i_req_divisor == ALL_ONES)) begin
            quot_d     = i_req_dividend;
            rem_d      = '0;
            divzero_d  = 1'b0;
            overflow_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_div_done) begin
          quot_d     = fix_quot;
          rem_d      = fix_rem;
          divzero_d  = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; everything freezes while the clock gate is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      signed_q   <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      divzero_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (i_cg) begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      signed_q   <= signed_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divzero_q  <= divzero_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake and core controls decode straight from the state register.
  assign o_req_ready     = (state_q == ST_IDLE);
  assign o_div_start     = (state_q == ST_START);
  assign o_rsp_valid     = (state_q == ST_RESP);
  assign o_div_dividend  = a_mag_q;
  assign o_div_divisor   = b_mag_q;
  assign o_rsp_quotient  = quot_q;
  assign o_rsp_remainder = rem_q;
  assign o_rsp_divzero   = divzero_q;
  assign o_rsp_overflow  = overflow_q;

endmodule

// File: tb/tb_divider_signed_frontend.sv
// Directed self-checking bench for divider_signed_frontend (WIDTH=8).
// The core is played by the bench: done pulses with hand-computed magnitudes.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_divider_signed_frontend;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_cg;
  logic         i_req_valid;
  logic         o_req_ready;
  logic         i_req_signed;
  logic [W-1:0] i_req_dividend;
  logic [W-1:0] i_req_divisor;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [W-1:0] o_rsp_quotient;
  logic [W-1:0] o_rsp_remainder;
  logic         o_rsp_divzero;
  logic         o_rsp_overflow;
  logic         o_div_start;
  logic [W-1:0] o_div_dividend;
  logic [W-1:0] o_div_divisor;
  logic         i_div_done;
  logic [W-1:0] i_div_quotient;
  logic [W-1:0] i_div_remainder;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  always #5 i_clk = ~i_clk;

  divider_signed_frontend #(.WIDTH(W)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_cg            (i_cg),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_signed    (i_req_signed),
    .i_req_dividend  (i_req_dividend),
    .i_req_divisor   (i_req_divisor),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_quotient  (o_rsp_quotient),
    .o_rsp_remainder (o_rsp_remainder),
    .o_rsp_divzero   (o_rsp_divzero),
    .o_rsp_overflow  (o_rsp_overflow),
    .o_div_start     (o_div_start),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_done      (i_div_done),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder)
  );

  // Effective starts as the core would see them (core shares the clock gate).
  always @(posedge i_clk) begin
    if (i_rst_n && i_cg && o_div_start) start_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One-cycle request; on return the DUT has taken the accept edge.
  task automatic send_req(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    i_req_valid    = 1'b1;
    i_req_signed   = sgn;
    i_req_dividend = a;
    i_req_divisor  = b;
    tick();
    i_req_valid    = 1'b0;
    i_req_dividend = 8'h5A;
    i_req_divisor  = 8'hA5;
  endtask

  task automatic core_done(input logic [W-1:0] q, input logic [W-1:0] r);
    i_div_done      = 1'b1;
    i_div_quotient  = q;
    i_div_remainder = r;
    tick();
    i_div_done      = 1'b0;
    i_div_quotient  = 8'h00;
    i_div_remainder = 8'h00;
  endtask

  task automatic consume();
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_cg = 1'b1; i_req_valid = 1'b0; i_req_signed = 1'b0;
    i_req_dividend = 8'h00; i_req_divisor = 8'h00; i_rsp_ready = 1'b0;
    i_div_done = 1'b0; i_div_quotient = 8'h00; i_div_remainder = 8'h00;
    repeat (2) tick();
    n_checks++;
    if ({o_req_ready, o_rsp_valid, o_div_start, o_rsp_divzero, o_rsp_overflow} !== 5'b10000)
      $display("FAIL reset_ctrl: got rdy/vld/start/dz/ov=%b want 10000",
               {o_req_ready, o_rsp_valid, o_div_start, o_rsp_divzero, o_rsp_overflow});
    else n_pass++;
    n_checks++;
    if ({o_rsp_quotient, o_rsp_remainder, o_div_dividend, o_div_divisor} !== 32'h0)
      $display("FAIL reset_data: got %h want 0",
               {o_rsp_quotient, o_rsp_remainder, o_div_dividend, o_div_divisor});
    else n_pass++;
    i_rst_n = 1'b1;
    tick();
    // Stray done in IDLE must not produce a response.
    core_done(8'h11, 8'h22);
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL idle_stray_done: got vld=%b rdy=%b want 0 1", o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    int s0 = start_cnt;
    send_req(1'b0, 8'd100, 8'd7);
    n_checks++;
    if (o_div_start !== 1'b1 || o_div_dividend !== 8'd100 || o_div_divisor !== 8'd7 || o_req_ready !== 1'b0)
      $display("FAIL unsigned_start: got start=%b dvd=%0d dvs=%0d rdy=%b want 1 100 7 0",
               o_div_start, o_div_dividend, o_div_divisor, o_req_ready);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (o_div_start !== 1'b0 || o_rsp_valid !== 1'b0 || o_div_dividend !== 8'd100 || o_div_divisor !== 8'd7)
      $display("FAIL unsigned_wait: got start=%b vld=%b dvd=%0d dvs=%0d want 0 0 100 7",
               o_div_start, o_rsp_valid, o_div_dividend, o_div_divisor);
    else n_pass++;
    core_done(8'd14, 8'd2);
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_quotient !== 8'd14 || o_rsp_remainder !== 8'd2 ||
        o_rsp_divzero !== 1'b0 || o_rsp_overflow !== 1'b0 || (start_cnt - s0) != 1)
      $display("FAIL unsigned_rsp: got vld=%b q=%0d r=%0d dz=%b ov=%b starts=%0d want 1 14 2 0 0 1",
               o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow, start_cnt - s0);
    else n_pass++;
    consume();
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL unsigned_consume: got vld=%b rdy=%b want 0 1", o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  task automatic test_signed();
    // -7 / 2 -> q=-3, r=-1
    send_req(1'b1, 8'hF9, 8'h02);
    n_checks++;
    if (o_div_dividend !== 8'd7 || o_div_divisor !== 8'd2)
      $display("FAIL signed_mag: got dvd=%0d dvs=%0d want 7 2", o_div_dividend, o_div_divisor);
    else n_pass++;
    tick();
    core_done(8'd3, 8'd1);
    n_checks++;
    if (o_rsp_quotient !== 8'hFD || o_rsp_remainder !== 8'hFF)
      $display("FAIL signed_neg_dvd: got q=%h r=%h want fd ff", o_rsp_quotient, o_rsp_remainder);
    else n_pass++;
    consume();
    // 7 / -2 -> q=-3, r=+1
    send_req(1'b1, 8'h07, 8'hFE);
    n_checks++;
    if (o_div_dividend !== 8'd7 || o_div_divisor !== 8'd2)
      $display("FAIL signed_mag2: got dvd=%0d dvs=%0d want 7 2", o_div_dividend, o_div_divisor);
    else n_pass++;
    tick();
    core_done(8'd3, 8'd1);
    n_checks++;
    if (o_rsp_quotient !== 8'hFD || o_rsp_remainder !== 8'h01)
      $display("FAIL signed_neg_dvs: got q=%h r=%h want fd 01", o_rsp_quotient, o_rsp_remainder);
    else n_pass++;
    consume();
  endtask

  task automatic test_special();
    int s0 = start_cnt;
    send_req(1'b0, 8'h2A, 8'h00);
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_quotient !== 8'hFF || o_rsp_remainder !== 8'h2A ||
        o_rsp_divzero !== 1'b1 || o_rsp_overflow !== 1'b0 || start_cnt != s0)
      $display("FAIL divzero: got vld=%b q=%h r=%h dz=%b ov=%b starts=%0d want 1 ff 2a 1 0 0",
               o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow, start_cnt - s0);
    else n_pass++;
    consume();
    send_req(1'b1, 8'h80, 8'hFF);
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_quotient !== 8'h80 || o_rsp_remainder !== 8'h00 ||
        o_rsp_divzero !== 1'b0 || o_rsp_overflow !== 1'b1 || start_cnt != s0)
      $display("FAIL overflow: got vld=%b q=%h r=%h dz=%b ov=%b starts=%0d want 1 80 00 0 1 0",
               o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow, start_cnt - s0);
    else n_pass++;
    consume();
    // Signed MIN_NEG / 0: divide-by-zero wins.
    send_req(1'b1, 8'h80, 8'h00);
    n_checks++;
    if (o_rsp_quotient !== 8'hFF || o_rsp_remainder !== 8'h80 || o_rsp_divzero !== 1'b1 || o_rsp_overflow !== 1'b0)
      $display("FAIL divzero_priority: got q=%h r=%h dz=%b ov=%b want ff 80 1 0",
               o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow);
    else n_pass++;
    consume();
    // Same overflow operands in unsigned mode go to the core.
    send_req(1'b0, 8'h80, 8'hFF);
    n_checks++;
    if (o_div_start !== 1'b1 || o_div_dividend !== 8'h80 || o_div_divisor !== 8'hFF)
      $display("FAIL unsigned_128_255_start: got start=%b dvd=%h dvs=%h want 1 80 ff",
               o_div_start, o_div_dividend, o_div_divisor);
    else n_pass++;
    tick();
    core_done(8'h00, 8'h80);
    n_checks++;
    if (o_rsp_quotient !== 8'h00 || o_rsp_remainder !== 8'h80 || o_rsp_overflow !== 1'b0 || o_rsp_divzero !== 1'b0)
      $display("FAIL unsigned_128_255_rsp: got q=%h r=%h dz=%b ov=%b want 00 80 0 0",
               o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow);
    else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    // -20 / 3 -> core 20/3 = 6 r 2 -> q=-6 (fa), r=-2 (fe)
    send_req(1'b1, 8'hEC, 8'h03);
    tick();
    core_done(8'd6, 8'd2);
    for (int i = 0; i < 5; i++) begin
      i_div_done      = 1'b1;
      i_div_quotient  = 8'h55 + 8'(i);
      i_div_remainder = 8'h33;
      n_checks++;
      if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_rsp_quotient !== 8'hFA ||
          o_rsp_remainder !== 8'hFE || o_rsp_divzero !== 1'b0 || o_rsp_overflow !== 1'b0)
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b q=%h r=%h dz=%b ov=%b want 1 0 fa fe 0 0",
                 i, o_rsp_valid, o_req_ready, o_rsp_quotient, o_rsp_remainder, o_rsp_divzero, o_rsp_overflow);
      else n_pass++;
      tick();
    end
    i_div_done = 1'b0;
    consume();
  endtask

  task automatic test_back_to_back();
    send_req(1'b0, 8'd9, 8'd4);
    tick();
    core_done(8'd2, 8'd1);
    // Request held valid while the response completes: not taken that cycle.
    i_req_valid = 1'b1; i_req_signed = 1'b0; i_req_dividend = 8'd50; i_req_divisor = 8'd5;
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    n_checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_div_start !== 1'b0)
      $display("FAIL b2b_no_accept: got rdy=%b vld=%b start=%b want 1 0 0", o_req_ready, o_rsp_valid, o_div_start);
    else n_pass++;
    tick();
    i_req_valid = 1'b0;
    n_checks++;
    if (o_div_start !== 1'b1 || o_div_dividend !== 8'd50 || o_div_divisor !== 8'd5)
      $display("FAIL b2b_accept: got start=%b dvd=%0d dvs=%0d want 1 50 5", o_div_start, o_div_dividend, o_div_divisor);
    else n_pass++;
    tick();
    core_done(8'd10, 8'd0);
    n_checks++;
    if (o_rsp_quotient !== 8'd10 || o_rsp_remainder !== 8'd0)
      $display("FAIL b2b_rsp: got q=%0d r=%0d want 10 0", o_rsp_quotient, o_rsp_remainder);
    else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_wait();
    send_req(1'b0, 8'd80, 8'd5);
    tick();
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_div_start !== 1'b0)
      $display("FAIL reset_async: got rdy=%b vld=%b start=%b want 1 0 0", o_req_ready, o_rsp_valid, o_div_start);
    else n_pass++;
    tick();
    i_rst_n = 1'b1;
    tick();
    core_done(8'd16, 8'd0);
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL reset_stale_done: got vld=%b rdy=%b want 0 1", o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  task automatic test_clock_gate();
    int s0 = start_cnt;
    send_req(1'b0, 8'd9, 8'd3);
    i_cg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_div_start !== 1'b1 || o_req_ready !== 1'b0 || o_div_dividend !== 8'd9 || start_cnt != s0)
        $display("FAIL cg_frozen[%0d]: got start=%b rdy=%b dvd=%0d starts=%0d want 1 0 9 0",
                 i, o_div_start, o_req_ready, o_div_dividend, start_cnt - s0);
      else n_pass++;
      tick();
    end
    i_cg = 1'b1;
    tick();
    n_checks++;
    if (o_div_start !== 1'b0 || (start_cnt - s0) != 1)
      $display("FAIL cg_single_start: got start=%b starts=%0d want 0 1", o_div_start, start_cnt - s0);
    else n_pass++;
    core_done(8'd3, 8'd0);
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_quotient !== 8'd3 || o_rsp_remainder !== 8'd0)
      $display("FAIL cg_rsp: got vld=%b q=%0d r=%0d want 1 3 0", o_rsp_valid, o_rsp_quotient, o_rsp_remainder);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_clock_gate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_signed_frontend.md
Name: divider_signed_frontend

Overview:
Request/response front end that sits directly upstream of the team's iterative unsigned divider core.
- Accepts signed or unsigned operand pairs on a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally, without starting the core.
- Otherwise converts operands to magnitudes, starts the core, waits for its done signal, sign-corrects the result, and holds it on a valid/ready response port until consumed.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cg  in  1  clock-gate enable; all state frozen when low
i_req_valid  in  1  request valid
o_req_ready  out  1  request ready
i_req_signed  in  1  1 = operands are two's complement
i_req_dividend  in  WIDTH  dividend
i_req_divisor  in  WIDTH  divisor
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed
o_rsp_quotient  out  WIDTH  quotient
o_rsp_remainder  out  WIDTH  remainder
o_rsp_divzero  out  1  divisor was zero
o_rsp_overflow  out  1  signed overflow case
o_div_start  out  1  one-cycle start to the core
o_div_dividend  out  WIDTH  unsigned magnitude to the core
o_div_divisor  out  WIDTH  unsigned magnitude to the core
i_div_done  in  1  core result valid
i_div_quotient  in  WIDTH  core unsigned quotient
i_div_remainder  in  WIDTH  core unsigned remainder

Behaviour:
- Reset and clocking:
  - One clock, i_clk.
  - i_rst_n is asynchronous and active-low.
  - Reset values: state=IDLE; o_rsp_valid=0; o_div_start=0; all registered result and operand fields 0; o_req_ready=1.
- Clock gating: state, operand and result registers update only when i_cg=1.
  - o_div_start is decoded from state, so it stays high while i_cg=0 in START.
  - The core shares i_cg, so it sees exactly one effective start.
- FSM states: IDLE, START, WAIT, RESP. o_req_ready = (state==IDLE).
- IDLE, on accept (i_req_valid && o_req_ready): register the signs, the magnitudes and i_req_signed.
  - Magnitude = two's-complement negate if signed and MSB set, else the raw value.
  - |0x80..0| = 0x80..0 is correct as unsigned.
- Special cases go IDLE->RESP directly; o_div_start never asserts:
  - Divisor==0: quotient=all-ones, remainder=raw dividend, divzero=1.
  - Signed, dividend=100..0 and divisor=all-ones: quotient=raw dividend, remainder=0, overflow=1.
  - Divzero takes priority; the two flags are never both set.
- Normal case: IDLE->START.
  - START asserts o_div_start for one effective cycle, then moves to WAIT.
  - o_div_dividend/o_div_divisor are held stable from START until leaving WAIT.
- WAIT: i_div_done is sampled only in this state. When it is high, register the corrected results and go to RESP.
  - Sign correction applies only in signed mode.
  - Quotient is negated iff the operand signs differ.
  - Remainder is negated iff the dividend was negative.
  - All arithmetic is mod 2^WIDTH.
- RESP: o_rsp_valid=1 with all response fields stable. On i_rsp_ready go to IDLE.
  - No new request is accepted in the cycle the response completes; ready returns the next cycle.
- Latency:
  - Special case accepted at cycle t: o_rsp_valid at t+1.
  - Normal case: start at t+1, core done at cycle d>t+1, o_rsp_valid at d+1.
- Stray i_div_done in IDLE, START or RESP is ignored.
- Reset mid-operation aborts immediately to IDLE with o_rsp_valid=0; any later stale done is ignored.
- i_req_* may change freely while o_req_ready=0.

Decomposition:
- Shared package (dividerPkg) holds:
  - the FSM state encoding (IDLE/START/WAIT/RESP, 2 bits);
  - localparam helpers for the MIN_NEG and ALL_ONES constants, expressed in terms of WIDTH.
- One natural combinational sub-module, divider_sign_fix (parameter WIDTH):
  - inputs: magnitude quotient/remainder, dividend sign, divisor sign, signed flag;
  - outputs: corrected quotient/remainder;
  - contains the shared two's-complement negate logic.

Test Plan:
1. Unsigned 100/7 (WIDTH=8) -> o_div_start once, o_div_dividend=100, o_div_divisor=7; core returns 14,2 -> rsp q=14 r=2, flags 0, valid at done+1.
2. Signed 0xF9/0x02 (-7/2) -> core sees 7/2; rsp q=0xFD (-3), r=0xFF (-1).
3. 0x2A/0x00 -> no start; next cycle rsp q=0xFF, r=0x2A, divzero=1.
4. Signed 0x80/0xFF -> no start; rsp q=0x80, r=0, overflow=1. The same operands unsigned -> start, core 128/255 -> q=0, r=0x80.
5. Backpressure: i_rsp_ready low for 5 cycles in RESP -> response fields stable, o_req_ready=0. Inject i_div_done pulses during RESP -> no change.
6. i_rst_n low for 1 cycle mid-WAIT -> immediate IDLE, o_req_ready=1. Later i_div_done -> no o_rsp_valid. i_cg=0 in START for 3 cycles -> state and outputs frozen, start seen once.
